// File: rtl/cmd_cfg_multi.sv
// Host command decoder: configuration register file plus per-channel RAM dump.
// Every host command produces a response byte; dumps stream ENTRIES bytes.
module cmd_cfg_multi #(
   parameter int ENTRIES = 384,
   parameter int LOG2    = 9,
   parameter int NUM_CH  = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [15:0]           cmd,
   input  logic                  cmd_rdy,
   input  logic                  resp_sent,
   input  logic                  set_capture_done,
   input  logic [LOG2-1:0]       ram_addr,
   input  logic [8*NUM_CH-1:0]   rdata,
   output logic [LOG2-1:0]       addr_ptr,
   output logic [7:0]            resp,
   output logic                  send_resp,
   output logic                  clr_cmd_rdy,
   output logic [5:0]            TrigCfg,
   output logic [5*NUM_CH-1:0]   CHTrigCfg,
   output logic [3:0]            decimator,
   output logic [7:0]            VIH,
   output logic [7:0]            VIL,
   output logic [7:0]            matchH,
   output logic [7:0]            matchL,
   output logic [7:0]            maskH,
   output logic [7:0]            maskL,
   output logic [7:0]            baud_cntH,
   output logic [7:0]            baud_cntL,
   output logic [LOG2-1:0]       trig_posH,
   output logic [LOG2-1:0]       trig_posL
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      RESP_WAIT = 3'd1,
      DUMP_RD   = 3'd2,
      DUMP_SEND = 3'd3,
      DUMP_WAIT = 3'd4
   } state_t;

   localparam logic [1:0] OP_RD   = 2'b00;
   localparam logic [1:0] OP_WR   = 2'b01;
   localparam logic [1:0] OP_DUMP = 2'b10;
   localparam logic [7:0] RESP_ACK = 8'hA5;
   localparam logic [7:0] RESP_ERR = 8'hEE;

   state_t            r_state, w_nxt_state;
   logic [LOG2-1:0]   r_addr_ptr, w_nxt_ptr;
   logic [LOG2-1:0]   r_cnt, w_nxt_cnt;
   logic [7:0]        r_resp, w_nxt_resp;
   logic              r_send, w_nxt_send;
   logic              r_clr, w_nxt_clr;
   logic [3:0]        r_ch, w_nxt_ch;

   logic [5:0]        r_trig;
   logic [4:0]        r_chcfg [NUM_CH];
   logic [3:0]        r_dec;
   logic [7:0]        r_vih, r_vil, r_mh, r_ml, r_kh, r_kl, r_bh, r_bl;
   logic [LOG2-1:0]   r_tph, r_tpl;

   logic [1:0]        w_op;
   logic [5:0]        w_addr;
   logic [2:0]        w_dch;
   logic              w_addr_ok, w_dump_ok, w_cmd_go, w_wr;
   logic [7:0]        w_rd_val, w_rbyte;

   assign w_op   = cmd[15:14];
   assign w_addr = cmd[13:8];
   assign w_dch  = cmd[10:8];

   assign w_addr_ok = (w_addr <= 6'h13) &&
                      !((w_addr >= 6'h01) && (w_addr <= 6'h08) && (w_addr > 6'(NUM_CH)));
   assign w_dump_ok = (w_dch != 3'd0) && ({1'b0, w_dch} <= 4'(NUM_CH));

   // cmd_rdy is still high during the clr_cmd_rdy cycle; don't re-run the command
   assign w_cmd_go = (r_state == IDLE) && cmd_rdy && !r_clr;
   assign w_wr     = w_cmd_go && (w_op == OP_WR) && w_addr_ok;

   always_comb begin
      w_rd_val = 8'h00;
      case (w_addr)
         6'h00:   w_rd_val = {2'b00, r_trig};
         6'h09:   w_rd_val = {4'h0, r_dec};
         6'h0A:   w_rd_val = r_vih;
         6'h0B:   w_rd_val = r_vil;
         6'h0C:   w_rd_val = r_mh;
         6'h0D:   w_rd_val = r_ml;
         6'h0E:   w_rd_val = r_kh;
         6'h0F:   w_rd_val = r_kl;
         6'h10:   w_rd_val = r_bh;
         6'h11:   w_rd_val = r_bl;
         6'h12:   w_rd_val = 8'(r_tph);
         6'h13:   w_rd_val = 8'(r_tpl);
         default: w_rd_val = 8'h00;
      endcase
      for (int i = 0; i < NUM_CH; i++)
         if (w_addr == 6'(i + 1)) w_rd_val = {3'b000, r_chcfg[i]};
   end

   always_comb begin
      w_rbyte = 8'h00;
      for (int i = 0; i < NUM_CH; i++)
         if (r_ch == 4'(i + 1)) w_rbyte = rdata[i*8 +: 8];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_addr_ptr <= '0;
         r_cnt      <= '0;
         r_resp     <= 8'h00;
         r_send     <= 1'b0;
         r_clr      <= 1'b0;
         r_ch       <= 4'd0;
      end else begin
         r_state    <= w_nxt_state;
         r_addr_ptr <= w_nxt_ptr;
         r_cnt      <= w_nxt_cnt;
         r_resp     <= w_nxt_resp;
         r_send     <= w_nxt_send;
         r_clr      <= w_nxt_clr;
         r_ch       <= w_nxt_ch;
      end
   end

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_ptr   = r_addr_ptr;
      w_nxt_cnt   = r_cnt;
      w_nxt_resp  = r_resp;
      w_nxt_send  = 1'b0;
      w_nxt_clr   = 1'b0;
      w_nxt_ch    = r_ch;
      case (r_state)
         IDLE: begin
            if (w_cmd_go) begin
               w_nxt_send  = 1'b1;
               w_nxt_state = RESP_WAIT;
               case (w_op)
                  OP_WR: w_nxt_resp = w_addr_ok ? RESP_ACK : RESP_ERR;
                  OP_RD: w_nxt_resp = w_addr_ok ? w_rd_val : RESP_ERR;
                  OP_DUMP: begin
                     if (w_dump_ok) begin
                        w_nxt_send  = 1'b0;
                        w_nxt_ptr   = ram_addr;
                        w_nxt_cnt   = '0;
                        w_nxt_ch    = {1'b0, w_dch};
                        w_nxt_state = DUMP_RD;
                     end else begin
                        w_nxt_resp = RESP_ERR;
                     end
                  end
                  default: w_nxt_resp = RESP_ERR;
               endcase
            end
         end
         RESP_WAIT: begin
            if (resp_sent) begin
               w_nxt_clr   = 1'b1;
               w_nxt_state = IDLE;
            end
         end
         DUMP_RD: w_nxt_state = DUMP_SEND;
         DUMP_SEND: begin
            w_nxt_resp  = w_rbyte;
            w_nxt_send  = 1'b1;
            w_nxt_state = DUMP_WAIT;
         end
         DUMP_WAIT: begin
            if (resp_sent) begin
               if (r_cnt == LOG2'(ENTRIES - 1)) begin
                  w_nxt_clr   = 1'b1;
                  w_nxt_state = IDLE;
               end else begin
                  w_nxt_cnt   = r_cnt + 1'b1;
                  w_nxt_ptr   = (r_addr_ptr == LOG2'(ENTRIES - 1)) ? '0 : r_addr_ptr + 1'b1;
                  w_nxt_state = DUMP_RD;
               end
            end
         end
         default: w_nxt_state = IDLE;
      endcase
   end

   // capture-done wins bit 5 over a coincident host write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_trig <= 6'h03;
      end else begin
         if (w_wr && (w_addr == 6'h00)) r_trig <= cmd[5:0];
         if (set_capture_done)          r_trig[5] <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) r_chcfg[i] <= 5'h01;
      end else begin
         for (int i = 0; i < NUM_CH; i++)
            if (w_wr && (w_addr == 6'(i + 1))) r_chcfg[i] <= cmd[4:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dec <= 4'h0;
         r_vih <= 8'hAA;
         r_vil <= 8'h55;
         r_mh  <= 8'h00;
         r_ml  <= 8'h00;
         r_kh  <= 8'h00;
         r_kl  <= 8'h00;
         r_bh  <= 8'h06;
         r_bl  <= 8'hC8;
         r_tph <= '0;
         r_tpl <= LOG2'(1);
      end else if (w_wr) begin
         case (w_addr)
            6'h09:   r_dec <= cmd[3:0];
            6'h0A:   r_vih <= cmd[7:0];
            6'h0B:   r_vil <= cmd[7:0];
            6'h0C:   r_mh  <= cmd[7:0];
            6'h0D:   r_ml  <= cmd[7:0];
            6'h0E:   r_kh  <= cmd[7:0];
            6'h0F:   r_kl  <= cmd[7:0];
            6'h10:   r_bh  <= cmd[7:0];
            6'h11:   r_bl  <= cmd[7:0];
            6'h12:   r_tph <= LOG2'(cmd[7:0]);
            6'h13:   r_tpl <= LOG2'(cmd[7:0]);
            default: ;
         endcase
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign CHTrigCfg[g*5 +: 5] = r_chcfg[g];
   end

   assign addr_ptr    = r_addr_ptr;
   assign resp        = r_resp;
   assign send_resp   = r_send;
   assign clr_cmd_rdy = r_clr;
   assign TrigCfg     = r_trig;
   assign decimator   = r_dec;
   assign VIH         = r_vih;
   assign VIL         = r_vil;
   assign matchH      = r_mh;
   assign matchL      = r_ml;
   assign maskH       = r_kh;
   assign maskL       = r_kl;
   assign baud_cntH   = r_bh;
   assign baud_cntL   = r_bl;
   assign trig_posH   = r_tph;
   assign trig_posL   = r_tpl;

endmodule

// File: tb/tb_cmd_cfg_multi.sv
// Scoreboard bench for cmd_cfg_multi: a register/RAM model predicts every
// response byte; a monitor with an attached UART model checks them in order.
module tb_cmd_cfg_multi;
   localparam int ENTRIES = 384;
   localparam int LOG2    = 9;
   localparam int NUM_CH  = 5;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [15:0]          cmd;
   logic                 cmd_rdy;
   logic                 resp_sent;
   logic                 set_capture_done;
   logic [LOG2-1:0]      ram_addr;
   logic [8*NUM_CH-1:0]  rdata;
   logic [LOG2-1:0]      addr_ptr;
   logic [7:0]           resp;
   logic                 send_resp;
   logic                 clr_cmd_rdy;
   logic [5:0]           TrigCfg;
   logic [5*NUM_CH-1:0]  CHTrigCfg;
   logic [3:0]           decimator;
   logic [7:0]           VIH, VIL, matchH, matchL, maskH, maskL, baud_cntH, baud_cntL;
   logic [LOG2-1:0]      trig_posH, trig_posL;

   cmd_cfg_multi #(.ENTRIES(ENTRIES), .LOG2(LOG2), .NUM_CH(NUM_CH)) dut (
      .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_rdy(cmd_rdy), .resp_sent(resp_sent),
      .set_capture_done(set_capture_done), .ram_addr(ram_addr), .rdata(rdata),
      .addr_ptr(addr_ptr), .resp(resp), .send_resp(send_resp), .clr_cmd_rdy(clr_cmd_rdy),
      .TrigCfg(TrigCfg), .CHTrigCfg(CHTrigCfg), .decimator(decimator),
      .VIH(VIH), .VIL(VIL), .matchH(matchH), .matchL(matchL), .maskH(maskH), .maskL(maskL),
      .baud_cntH(baud_cntH), .baud_cntL(baud_cntL), .trig_posH(trig_posH), .trig_posL(trig_posL)
   );

   always #5 clk = ~clk;

   int  mem [NUM_CH][ENTRIES];
   int  m [0:19];
   int  exp_q [$];
   int  n_checks = 0, n_errs = 0, n_sends = 0, n_clr = 0;
   bit  pending = 0;

   // synchronous-read RAM
   always @(posedge clk)
      for (int c = 0; c < NUM_CH; c++) rdata[c*8 +: 8] <= 8'(mem[c][addr_ptr]);

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic bit valid(input int a);
      return (a <= 'h13) && !(a >= 1 && a <= 8 && a > NUM_CH);
   endfunction

   function automatic int wmask(input int a);
      if (a == 0) return 'h3F;
      if (a <= 8) return 'h1F;
      if (a == 9) return 'h0F;
      if (a >= 'h12) return (1 << LOG2) - 1;
      return 'hFF;
   endfunction

   task automatic model_reset();
      m[0] = 'h03;
      for (int i = 1; i <= 8; i++) m[i] = 'h01;
      m[9] = 0; m[10] = 'hAA; m[11] = 'h55;
      for (int i = 12; i <= 15; i++) m[i] = 0;
      m[16] = 'h06; m[17] = 'hC8; m[18] = 0; m[19] = 1;
   endtask

   task automatic push_expected(input logic [15:0] c);
      int op, a, d, n;
      op = int'(c[15:14]); a = int'(c[13:8]); d = int'(c[7:0]); n = int'(c[10:8]);
      case (op)
         1: if (valid(a)) begin m[a] = d & wmask(a); exp_q.push_back('hA5); end
            else exp_q.push_back('hEE);
         0: exp_q.push_back(valid(a) ? (m[a] & 'hFF) : 'hEE);
         2: if (n >= 1 && n <= NUM_CH)
               for (int i = 0; i < ENTRIES; i++)
                  exp_q.push_back(mem[n-1][(int'(ram_addr) + i) % ENTRIES]);
            else exp_q.push_back('hEE);
         default: exp_q.push_back('hEE);
      endcase
   endtask

   task automatic check_regs();
      check("TrigCfg", int'(TrigCfg), m[0]);
      for (int i = 0; i < NUM_CH; i++)
         check($sformatf("CH%0dTrigCfg", i + 1), int'(CHTrigCfg[i*5 +: 5]), m[i+1]);
      check("decimator", int'(decimator), m[9]);
      check("VIH", int'(VIH), m[10]);
      check("VIL", int'(VIL), m[11]);
      check("matchH", int'(matchH), m[12]);
      check("matchL", int'(matchL), m[13]);
      check("maskH", int'(maskH), m[14]);
      check("maskL", int'(maskL), m[15]);
      check("baud_cntH", int'(baud_cntH), m[16]);
      check("baud_cntL", int'(baud_cntL), m[17]);
      check("trig_posH", int'(trig_posH), m[18]);
      check("trig_posL", int'(trig_posL), m[19]);
   endtask

   // monitor + UART model: pop/compare on each send_resp, answer with resp_sent
   initial begin
      int cd;
      int e;
      cd = 0;
      resp_sent = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            pending = 0; cd = 0; resp_sent = 1'b0;
         end else begin
            resp_sent = 1'b0;
            if (send_resp) begin
               n_sends++;
               check("send_before_resp_sent", int'(pending), 0);
               if (exp_q.size() == 0) begin
                  n_checks++; n_errs++;
                  $display("FAIL unexpected_resp: got 0x%0h, expected no byte", resp);
               end else begin
                  e = exp_q.pop_front();
                  check("resp_byte", int'(resp), e);
               end
               pending = 1;
               cd = $urandom_range(1, 3);
            end
            if (clr_cmd_rdy) n_clr++;
            if (cd > 0) begin
               cd--;
               if (cd == 0) begin resp_sent = 1'b1; pending = 0; end
            end
         end
      end
   end

   task automatic do_cmd(input logic [15:0] c, input bit cap, input bit scramble);
      int  base_clr;
      bit  done;
      push_expected(c);
      if (cap) m[0] = m[0] | 'h20;
      base_clr = n_clr;
      @(negedge clk);
      cmd = c; cmd_rdy = 1'b1; set_capture_done = cap;
      @(negedge clk);
      set_capture_done = 1'b0;
      done = 0;
      for (int k = 0; k < 4000 && !done; k++) begin
         if (clr_cmd_rdy) done = 1;
         else begin
            if (scramble && k == 40) ram_addr = LOG2'($urandom_range(0, ENTRIES - 1));
            @(negedge clk);
         end
      end
      cmd_rdy = 1'b0;
      check($sformatf("cmd_%04h_done", c), int'(done), 1);
      repeat (2) @(negedge clk);
      check($sformatf("cmd_%04h_clr_once", c), n_clr - base_clr, 1);
      check($sformatf("cmd_%04h_all_bytes", c), exp_q.size(), 0);
      exp_q.delete();
      check_regs();
   endtask

   initial begin
      int dumps, base;
      logic [1:0] op;
      logic [5:0] a;
      logic [2:0] n;
      for (int c = 0; c < NUM_CH; c++)
         for (int k = 0; k < ENTRIES; k++)
            mem[c][k] = (c == 2) ? ((k + 3) & 'hFF) : int'($urandom_range(0, 255));
      rst_n = 1'b0; cmd = 16'h0; cmd_rdy = 1'b0; set_capture_done = 1'b0; ram_addr = '0;
      model_reset();
      repeat (3) @(negedge clk);
      check("rst_addr_ptr", int'(addr_ptr), 0);
      check("rst_resp", int'(resp), 0);
      check("rst_send_resp", int'(send_resp), 0);
      check("rst_clr_cmd_rdy", int'(clr_cmd_rdy), 0);
      check_regs();
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      do_cmd(16'h4BAF, 0, 0);
      do_cmd(16'h0B00, 0, 0);
      do_cmd(16'h6BAF, 0, 0);
      do_cmd(16'h2C00, 0, 0);
      ram_addr = '0;
      do_cmd(16'h8300, 0, 1);
      ram_addr = LOG2'(380);
      do_cmd(16'h8100, 0, 1);
      do_cmd(16'h8600, 0, 0);
      do_cmd(16'h8000, 0, 0);
      do_cmd(16'hC000, 0, 0);
      do_cmd(16'h0600, 0, 0);
      do_cmd(16'h4513, 0, 0);
      do_cmd(16'h0500, 0, 0);
      do_cmd(16'h4000, 1, 0);
      do_cmd(16'h0000, 0, 0);
      do_cmd(16'h4003, 0, 0);
      do_cmd(16'h0000, 0, 0);
      do_cmd(16'h52FF, 0, 0);
      do_cmd(16'h1200, 0, 0);

      dumps = 0;
      for (int i = 0; i < 40; i++) begin
         op = 2'($urandom_range(0, 3));
         a  = 6'($urandom_range(0, 'h17));
         if (op == 2'b10) begin
            if (dumps >= 2) op = 2'b00;
            else begin
               dumps++;
               n = 3'($urandom_range(0, 7));
               a = {3'($urandom_range(0, 7)), n};
               ram_addr = LOG2'($urandom_range(0, ENTRIES - 1));
            end
         end
         do_cmd({op, a, 8'($urandom_range(0, 255))}, 0, op == 2'b10);
      end

      // reset in the middle of a dump
      push_expected(16'h8200);
      base = n_sends;
      @(negedge clk);
      cmd = 16'h8200; cmd_rdy = 1'b1;
      for (int k = 0; k < 3000 && (n_sends - base) < 100; k++) @(negedge clk);
      check("dump_reached_byte_100", n_sends - base, 100);
      #1;
      rst_n = 1'b0; cmd_rdy = 1'b0;
      exp_q.delete();
      model_reset();
      @(negedge clk);
      check("midrst_addr_ptr", int'(addr_ptr), 0);
      check("midrst_resp", int'(resp), 0);
      check("midrst_send_resp", int'(send_resp), 0);
      check("midrst_clr_cmd_rdy", int'(clr_cmd_rdy), 0);
      check_regs();
      base = n_sends;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      check("no_send_after_reset", n_sends - base, 0);
      do_cmd(16'h0A00, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end
endmodule
